// File: rtl/m32_io_uart_responder_pkg.sv
// Shared definitions for the memory-mapped UART responder: register offsets,
// STATUS bit positions, I/O space base and the serial FSM state type.
package m32_io_uart_responder_pkg;

  localparam logic [31:0] IO_BASE = 32'hA000_0000;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_RXDATA  = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [1:0] REG_BAUDDIV = 2'd3;

  localparam int ST_TXFULL   = 0;
  localparam int ST_TXEMPTY  = 1;
  localparam int ST_TXBUSY   = 2;
  localparam int ST_RXVALID  = 3;
  localparam int ST_RXFULL   = 4;
  localparam int ST_OVERRUN  = 5;
  localparam int ST_FRAMEERR = 6;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/m32_sync_fifo.sv
// Synchronous FIFO with full/empty/count; a push while full is accepted only
// when a pop happens in the same cycle.
module m32_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (do_pop && !do_push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/m32_io_uart_responder.sv
// Memory-mapped 8N1 UART on the core I/O space: register decode with
// combinational read data, TX serializer and RX deserializer behind FIFOs.
module m32_io_uart_responder
  import m32_io_uart_responder_pkg::*;
#(
  parameter int FIFO_DEPTH  = 4,
  parameter int DEFAULT_DIV = 433,
  parameter int DIV_W       = 16
) (
  input  logic        coreClk,
  input  logic        coreRst,
  input  logic [31:0] ioAddr,
  input  logic [31:0] ioWdata,
  input  logic        ioWr_n,
  input  logic        ioRd_n,
  output logic [31:0] ioRdata,
  output logic        uartTx,
  input  logic        uartRx,
  output logic        irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // First sample point sits (DIV+1)/2 clocks after the detected falling edge.
  function automatic logic [DIV_W-1:0] half_period_m1(input logic [DIV_W-1:0] div);
    logic [DIV_W:0] h;
    h = ({1'b0, div} + (DIV_W+1)'(1)) >> 1;
    return (h == '0) ? '0 : DIV_W'(h - (DIV_W+1)'(1));
  endfunction

  logic [1:0] reg_sel;
  logic       wr_en, rd_en;
  logic       tx_push, tx_pop, rx_push, rx_pop;
  logic       st_wr, div_wr;
  logic [7:0] tx_head, rx_head;
  logic       tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;

  logic [DIV_W-1:0] div_q;
  logic             ovr_q, ovr_d, fe_q, fe_d;
  logic             ovr_set, fe_set;

  uart_state_e      tx_state_q, tx_state_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic             tx_line_q, tx_line_d;

  uart_state_e      rx_state_q, rx_state_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_s1_q, rx_s2_q, rx_s3_q, rx_fall;

  logic [31:0] status;
  logic        unused_bits;

  assign reg_sel = ioAddr[3:2];
  assign wr_en   = !ioWr_n;
  assign rd_en   = !ioRd_n;
  assign tx_push = wr_en && (reg_sel == REG_TXDATA);
  assign st_wr   = wr_en && (reg_sel == REG_STATUS);
  assign div_wr  = wr_en && (reg_sel == REG_BAUDDIV);
  assign rx_pop  = rd_en && (reg_sel == REG_RXDATA) && !rx_empty;

  m32_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i   (coreClk),
    .rst_ni  (coreRst),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .wdata_i (ioWdata[7:0]),
    .rdata_o (tx_head),
    .full_o  (tx_full),
    .empty_o (tx_empty),
    .count_o (tx_count)
  );

  m32_sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i   (coreClk),
    .rst_ni  (coreRst),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .wdata_i (rx_shift_q),
    .rdata_o (rx_head),
    .full_o  (rx_full),
    .empty_o (rx_empty),
    .count_o (rx_count)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_head;
          tx_cnt_d   = div_q;
          tx_state_d = S_START;
        end
      end
      S_START: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = div_q;
          tx_bit_d   = 3'd0;
          tx_state_d = S_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q - DIV_W'(1);
        end
      end
      S_DATA: begin
        if (tx_cnt_q == '0) begin
          tx_cnt_d   = div_q;
          tx_shift_d = tx_shift_q >> 1;
          if (tx_bit_q == 3'd7) tx_state_d = S_STOP;
          else                  tx_bit_d   = tx_bit_q + 3'd1;
        end else begin
          tx_cnt_d = tx_cnt_q - DIV_W'(1);
        end
      end
      S_STOP: begin
        if (tx_cnt_q == '0) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_head;
            tx_cnt_d   = div_q;
            tx_state_d = S_START;
          end else begin
            tx_state_d = S_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q - DIV_W'(1);
        end
      end
      default: tx_state_d = S_IDLE;
    endcase
    // Line level is registered from the next state so it never glitches.
    tx_line_d = 1'b1;
    if (tx_state_d == S_START)     tx_line_d = 1'b0;
    else if (tx_state_d == S_DATA) tx_line_d = tx_shift_d[0];
  end

  assign rx_fall = rx_s3_q && !rx_s2_q;

  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    ovr_set    = 1'b0;
    fe_set     = 1'b0;
    case (rx_state_q)
      S_IDLE: begin
        if (rx_fall) begin
          rx_cnt_d   = half_period_m1(div_q);
          rx_state_d = S_START;
        end
      end
      S_START: begin
        if (rx_cnt_q == '0) begin
          if (rx_s2_q) begin
            rx_state_d = S_IDLE;
          end else begin
            rx_cnt_d   = div_q;
            rx_bit_d   = 3'd0;
            rx_state_d = S_DATA;
          end
        end else begin
          rx_cnt_d = rx_cnt_q - DIV_W'(1);
        end
      end
      S_DATA: begin
        if (rx_cnt_q == '0) begin
          rx_cnt_d   = div_q;
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = S_STOP;
          else                  rx_bit_d   = rx_bit_q + 3'd1;
        end else begin
          rx_cnt_d = rx_cnt_q - DIV_W'(1);
        end
      end
      S_STOP: begin
        if (rx_cnt_q == '0) begin
          rx_state_d = S_IDLE;
          if (!rx_s2_q)               fe_set  = 1'b1;
          else if (rx_full && !rx_pop) ovr_set = 1'b1;
          else                        rx_push = 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q - DIV_W'(1);
        end
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  // Sticky flags: W1C clear first so a same-cycle set wins.
  always_comb begin
    ovr_d = ovr_q;
    fe_d  = fe_q;
    if (st_wr && ioWdata[ST_OVERRUN])  ovr_d = 1'b0;
    if (st_wr && ioWdata[ST_FRAMEERR]) fe_d  = 1'b0;
    if (ovr_set) ovr_d = 1'b1;
    if (fe_set)  fe_d  = 1'b1;
  end

  always_ff @(posedge coreClk) begin
    if (!coreRst) begin
      tx_state_q <= S_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_line_q  <= 1'b1;
      rx_state_q <= S_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      ovr_q      <= 1'b0;
      fe_q       <= 1'b0;
      div_q      <= DIV_W'(DEFAULT_DIV);
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_line_q  <= tx_line_d;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_s1_q    <= uartRx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      ovr_q      <= ovr_d;
      fe_q       <= fe_d;
      if (div_wr) div_q <= ioWdata[DIV_W-1:0];
    end
  end

  always_ff @(posedge coreClk) begin
    tx_shift_q <= tx_shift_d;
    rx_shift_q <= rx_shift_d;
  end

  always_comb begin
    status               = '0;
    status[ST_TXFULL]    = tx_full;
    status[ST_TXEMPTY]   = tx_empty;
    status[ST_TXBUSY]    = (tx_state_q != S_IDLE);
    status[ST_RXVALID]   = !rx_empty;
    status[ST_RXFULL]    = rx_full;
    status[ST_OVERRUN]   = ovr_q;
    status[ST_FRAMEERR]  = fe_q;
  end

  always_comb begin
    ioRdata = '0;
    if (rd_en) begin
      case (reg_sel)
        REG_RXDATA:  if (!rx_empty) ioRdata = {24'b0, rx_head};
        REG_STATUS:  ioRdata = status;
        REG_BAUDDIV: ioRdata = {{(32-DIV_W){1'b0}}, div_q};
        default:     ioRdata = '0;
      endcase
    end
  end

  assign uartTx = tx_line_q;
  assign irq    = !rx_empty || ovr_q || fe_q;

  assign unused_bits = ^{ioAddr[31:4], ioAddr[1:0], ioWdata[31:DIV_W], tx_count, rx_count};

endmodule

// File: tb/tb_m32_io_uart_responder.sv
// Directed + randomized bench for the memory-mapped UART responder, with a
// line-level TX decoder and a queue-based RX/flag reference model.
module tb_m32_io_uart_responder;

  logic        coreClk = 1'b0;
  logic        coreRst;
  logic [31:0] ioAddr, ioWdata, ioRdata;
  logic        ioWr_n, ioRd_n;
  logic        uartTx, uartRx, irq;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int P        = 434;

  logic [9:0] tx_frames[$];
  int         tx_starts[$];
  logic [7:0] rx_model[$];
  logic       m_ovr = 1'b0;
  logic       m_fe  = 1'b0;

  m32_io_uart_responder dut (
    .coreClk (coreClk),
    .coreRst (coreRst),
    .ioAddr  (ioAddr),
    .ioWdata (ioWdata),
    .ioWr_n  (ioWr_n),
    .ioRd_n  (ioRd_n),
    .ioRdata (ioRdata),
    .uartTx  (uartTx),
    .uartRx  (uartRx),
    .irq     (irq)
  );

  always #5 coreClk = ~coreClk;
  always @(posedge coreClk) cyc <= cyc + 1;

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  // Line-level decoder: mid-bit sampling of each 8N1 frame seen on uartTx.
  initial begin : tx_mon
    logic [9:0] bits;
    int st;
    forever begin
      @(posedge coreClk); #2;
      if (uartTx === 1'b0) begin
        st = cyc;
        bits = '0;
        repeat (P/2) begin @(posedge coreClk); #2; end
        bits[0] = uartTx;
        for (int k = 1; k < 10; k++) begin
          repeat (P) begin @(posedge coreClk); #2; end
          bits[k] = uartTx;
        end
        tx_frames.push_back(bits);
        tx_starts.push_back(st);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge coreClk); #1;
  endtask

  task automatic io_write(input logic [31:0] a, input logic [31:0] d);
    ioAddr = a; ioWdata = d; ioWr_n = 1'b0;
    tick();
    ioWr_n = 1'b1;
  endtask

  task automatic io_read(input logic [31:0] a, output logic [31:0] d);
    ioAddr = a; ioRd_n = 1'b0;
    #1 d = ioRdata;
    tick();
    ioRd_n = 1'b1;
  endtask

  task automatic set_div(input int d);
    io_write(32'hA000_000C, d);
    P = d + 1;
  endtask

  // Drives one frame and applies the receive rules to the reference model.
  task automatic send_frame(input logic [7:0] b, input logic stop);
    uartRx = 1'b0;
    repeat (P) tick();
    for (int k = 0; k < 8; k++) begin
      uartRx = b[k];
      repeat (P) tick();
    end
    uartRx = stop;
    repeat (P) tick();
    uartRx = 1'b1;
    repeat (4) tick();
    if (!stop)                    m_fe = 1'b1;
    else if (rx_model.size() == 4) m_ovr = 1'b1;
    else                          rx_model.push_back(b);
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = 32'h0000_0002;
    if (rx_model.size() != 0) s[3] = 1'b1;
    if (rx_model.size() == 4) s[4] = 1'b1;
    s[5] = m_ovr;
    s[6] = m_fe;
    return s;
  endfunction

  task automatic read_rx_check(input string tag);
    logic [31:0] rd, exp;
    exp = (rx_model.size() != 0) ? {24'b0, rx_model.pop_front()} : 32'h0;
    io_read(32'hA000_0004, rd);
    check(tag, rd, exp);
  endtask

  initial begin : main
    logic [31:0] rd;
    logic [7:0]  b;
    logic [7:0]  sent[$];
    logic [9:0]  exp_frame;
    int          wave[10];
    int          busy;
    int          n;

    coreRst = 1'b0; ioAddr = '0; ioWdata = '0; ioWr_n = 1'b1; ioRd_n = 1'b1; uartRx = 1'b1;
    repeat (3) tick();
    coreRst = 1'b1;
    tick();

    io_read(32'hA000_0008, rd);  check("reset_status", rd, 32'h2);
    check("reset_uartTx", uartTx, 1);
    check("reset_irq", irq, 0);
    io_read(32'hA000_000C, rd);  check("reset_bauddiv", rd, 433);
    io_read(32'hA000_0000, rd);  check("txdata_reads_zero", rd, 0);
    set_div(3);
    io_read(32'hA000_000C, rd);  check("bauddiv_written", rd, 3);

    // Single frame 0xA5: waveform and busy duration
    tx_frames.delete(); tx_starts.delete();
    io_write(32'hA000_0000, 32'hA5);
    busy = 0;
    ioAddr = 32'hA000_0008; ioRd_n = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (ioRdata[2]) busy++;
      tick();
    end
    ioRd_n = 1'b1;
    repeat (10) tick();
    check("txbusy_clocks", busy, 40);
    check("a5_frame_count", tx_frames.size(), 1);
    wave = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    for (int k = 0; k < 10; k++) exp_frame[k] = wave[k][0];
    if (tx_frames.size() > 0) check("a5_waveform", tx_frames[0], exp_frame);

    // Five back-to-back bytes plus one dropped while full
    tx_frames.delete(); tx_starts.delete();
    for (int i = 1; i <= 5; i++) io_write(32'hA000_0000, i * 32'h11);
    io_read(32'hA000_0008, rd);  check("txfull_after_5", rd[0], 1);
    io_write(32'hA000_0000, 32'h66);
    repeat (240) tick();
    check("b2b_frame_count", tx_frames.size(), 5);
    for (int i = 0; i < tx_frames.size() && i < 5; i++) begin
      b = 8'((i + 1) * 'h11);
      check($sformatf("b2b_frame%0d", i), tx_frames[i], {1'b1, b, 1'b0});
      if (i > 0) check($sformatf("b2b_gap%0d", i), tx_starts[i] - tx_starts[i-1], 10 * P);
    end
    io_read(32'hA000_0008, rd);  check("tx_idle_status", rd, 32'h2);

    // Randomized TX bursts (never more than the FIFO can absorb)
    for (int r = 0; r < 2; r++) begin
      tx_frames.delete(); tx_starts.delete(); sent.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        b = 8'($urandom);
        sent.push_back(b);
        io_write(32'hA000_0000, {24'b0, b});
      end
      repeat (n * 40 + 30) tick();
      check($sformatf("rand_tx%0d_count", r), tx_frames.size(), n);
      for (int i = 0; i < n && i < tx_frames.size(); i++)
        check($sformatf("rand_tx%0d_frame%0d", r, i), tx_frames[i], {1'b1, sent[i], 1'b0});
    end

    // Single RX frame
    send_frame(8'h3C, 1'b1);
    io_read(32'hA000_0008, rd);  check("rx_valid_status", rd, model_status());
    check("rx_irq", irq, 1);
    read_rx_check("rxdata_3c");
    io_read(32'hA000_0008, rd);  check("rx_after_pop_status", rd, model_status());
    read_rx_check("rxdata_empty");
    check("rx_irq_clear", irq, 0);

    // Overrun, W1C and frame error
    for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1);
    io_read(32'hA000_0008, rd);  check("overrun_status", rd, model_status());
    check("overrun_irq", irq, 1);
    io_write(32'hA000_0008, 32'h20);
    m_ovr = 1'b0;
    io_read(32'hA000_0008, rd);  check("overrun_w1c", rd, model_status());
    for (int i = 0; i < 4; i++) read_rx_check($sformatf("rx_fifo%0d", i));
    send_frame(8'($urandom), 1'b0);
    io_read(32'hA000_0008, rd);  check("frameerr_status", rd, model_status());
    check("frameerr_irq", irq, 1);
    io_write(32'hA000_0008, 32'h40);
    m_fe = 1'b0;
    io_read(32'hA000_0008, rd);  check("frameerr_w1c", rd, model_status());

    // Randomized single-frame receives
    for (int r = 0; r < 3; r++) begin
      send_frame(8'($urandom), 1'b1);
      read_rx_check($sformatf("rand_rx%0d", r));
    end

    // Reset mid-frame with a byte still queued
    io_write(32'hA000_0000, 32'h0F);
    io_write(32'hA000_0000, 32'hF0);
    repeat (15) tick();
    coreRst = 1'b0;
    tick();
    check("midframe_reset_tx", uartTx, 1);
    io_read(32'hA000_0008, rd);  check("midframe_reset_status", rd, 32'h2);
    coreRst = 1'b1;
    tick();
    io_read(32'hA000_000C, rd);  check("midframe_reset_div", rd, 433);
    repeat (60) tick();
    tx_frames.delete(); tx_starts.delete();
    set_div(3);
    repeat (100) tick();
    check("no_tx_after_reset", tx_frames.size(), 0);

    // Short low glitch on the receive line, then a real frame
    uartRx = 1'b0;
    tick();
    uartRx = 1'b1;
    repeat (20) tick();
    io_read(32'hA000_0008, rd);  check("glitch_status", rd, model_status());
    check("glitch_irq", irq, 0);
    send_frame(8'h5A, 1'b1);
    read_rx_check("rx_after_glitch");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
